// File: rtl/addsub_rr_arbiter_if.sv
// Request/response/adder bundle for addsub_rr_arbiter.
// slave  : the arbiter's view (takes requests, drives responses and the adder inputs).
// master : the environment's view (clients plus the shared adder_sub).
interface addsub_rr_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [4*NREQ-1:0] rsp_sum;
  logic [NREQ-1:0]   rsp_cout;
  logic [NREQ-1:0]   rsp_ovf;
  logic [3:0]        au_a;
  logic [3:0]        au_b;
  logic              au_ctrl;
  logic [3:0]        au_s;
  logic [3:0]        au_c;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready, au_s, au_c,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, au_a, au_b, au_ctrl
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready, au_s, au_c,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, au_a, au_b, au_ctrl
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sharing of one external 4-bit adder_sub among NREQ requesters.
// Grant and adder drive are combinational; each port owns a registered result
// slot that is never overwritten while unconsumed.
// Optional macro ADDSUB_ARB_STATS_EN adds saturating op_count / stall_count outputs.
module addsub_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_rr_arbiter_if.slave   bus
`ifdef ADDSUB_ARB_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;

  logic            rsp_valid_reg [NREQ];
  logic [3:0]      rsp_sum_reg   [NREQ];
  logic            rsp_cout_reg  [NREQ];
  logic            rsp_ovf_reg   [NREQ];
  logic [NREQ-1:0] rsp_valid_vec;

  // A port may be served only if its result slot is empty or being drained now.
  always_comb begin
    elig = bus.req_valid & (~rsp_valid_vec | bus.rsp_ready);
  end

  // Scan from the RR pointer; first eligible port wins. No grants while in reset.
  always_comb begin
    int idx;
    int nxt;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!grant_any && elig[idx] && !rst) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    nxt      = (int'(grant_idx) + 1) % NREQ;
    ptr_next = PW'(nxt);
  end

  // Steer the granted port's operands to the shared adder; idle inputs are zero.
  always_comb begin
    bus.au_a    = 4'h0;
    bus.au_b    = 4'h0;
    bus.au_ctrl = 1'b0;
    if (grant_any) begin
      bus.au_a    = bus.req_a[int'(grant_idx)*4 +: 4];
      bus.au_b    = bus.req_b[int'(grant_idx)*4 +: 4];
      bus.au_ctrl = bus.req_sub[grant_idx];
    end
  end

  // Advance the pointer past the last winner; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= ptr_next;
    end
  end

  assign bus.req_ready = grant;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
      // Per-port result slot: load on grant (wins over a same-cycle consume), else clear on consume.
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_sum_reg[gi]   <= 4'h0;
          rsp_cout_reg[gi]  <= 1'b0;
          rsp_ovf_reg[gi]   <= 1'b0;
        end else if (grant[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_sum_reg[gi]   <= bus.au_s;
          rsp_cout_reg[gi]  <= bus.au_c[3];
          rsp_ovf_reg[gi]   <= bus.au_c[3] ^ bus.au_c[2];
        end else if (rsp_valid_reg[gi] && bus.rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end

      assign rsp_valid_vec[gi]       = rsp_valid_reg[gi];
      assign bus.rsp_valid[gi]       = rsp_valid_reg[gi];
      assign bus.rsp_sum[gi*4 +: 4]  = rsp_sum_reg[gi];
      assign bus.rsp_cout[gi]        = rsp_cout_reg[gi];
      assign bus.rsp_ovf[gi]         = rsp_ovf_reg[gi];
    end
  endgenerate

`ifdef ADDSUB_ARB_STATS_EN
  logic        stall_any;
  logic [15:0] op_count_reg;
  logic [15:0] stall_count_reg;

  assign stall_any = |(bus.req_valid & ~grant);

  // Saturating activity counters: granted ops and cycles with a losing request.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg    <= 16'h0000;
      stall_count_reg <= 16'h0000;
    end else begin
      if (grant_any && op_count_reg != 16'hFFFF) op_count_reg <= op_count_reg + 16'd1;
      if (stall_any && stall_count_reg != 16'hFFFF) stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign op_count    = op_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule
